// File: rtl/alu_pkg.sv
// Shared types and constants for the ARM-style data-processing ALU.
// Optional build macro: ALU_LOGIC_CARRY_CLR_EN (see alu_processor.sv).
package alu_pkg;

    typedef enum logic [3:0] {
        AND = 4'd0,
        EOR = 4'd1,
        ORR = 4'd2,
        NOR = 4'd3,
        BIC = 4'd4,
        ADD = 4'd5,
        ADC = 4'd6,
        SUB = 4'd7,
        SBC = 4'd8,
        RSB = 4'd9,
        RSC = 4'd10,
        TEQ = 4'd11,
        CMP = 4'd12,
        CMN = 4'd13,
        MOV = 4'd14,
        MVN = 4'd15
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // True for the opcodes whose C/V come from the adder.
    function automatic logic is_arith(input alu_op_e op);
        case (op)
            ADD, ADC, SUB, SBC, RSB, RSC, CMP, CMN: is_arith = 1'b1;
            default:                                is_arith = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_processor_if.sv
// Operand/result bundle between the execute-stage sequencer (master) and the ALU (slave).
// There is no handshake: a new operation is accepted every clock and its result appears one clock later.
interface alu_processor_if #(
    parameter int N = 32
);
    logic [3:0]   opcode;
    logic [N-1:0] op1;
    logic [N-1:0] op2;
    logic [3:0]   old_ALU_flag_NZCV;
    logic [N-1:0] out;
    logic [3:0]   ALU_flag_NZCV;

    modport master (
        output opcode, op1, op2, old_ALU_flag_NZCV,
        input  out, ALU_flag_NZCV
    );

    modport slave (
        input  opcode, op1, op2, old_ALU_flag_NZCV,
        output out, ALU_flag_NZCV
    );
endinterface

// File: rtl/alu_addsub.sv
// N-bit adder a + b + cin with carry-out and signed overflow; subtraction is
// done by the caller feeding an inverted subtrahend.
module alu_addsub #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout,
    output logic         o_ovf
);

    logic [N:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};
    assign o_sum  = w_full[N-1:0];
    assign o_cout = w_full[N];
    // Overflow: adder inputs agree in sign but the sum does not.
    assign o_ovf  = (i_a[N-1] == i_b[N-1]) && (w_full[N-1] != i_a[N-1]);

endmodule

// File: rtl/alu_processor.sv
// Registered 16-opcode data-processing ALU producing a result and new NZCV flags.
// Define ALU_LOGIC_CARRY_CLR_EN to make logic/move ops clear C and V instead of preserving them.
module alu_processor
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_processor_if.slave     bus
);

    alu_op_e      w_op;
    logic         w_cin_flag;
    logic [N-1:0] w_add_a;
    logic [N-1:0] w_add_b;
    logic         w_add_cin;
    logic [N-1:0] w_sum;
    logic         w_cout;
    logic         w_ovf;
    logic [N-1:0] w_logic_res;
    logic [N-1:0] w_res;
    logic [1:0]   w_logic_cv;
    logic [3:0]   w_flags;
    logic         w_unused_flags;
    logic [N-1:0] r_out;
    logic [3:0]   r_flags;

    assign w_op       = alu_op_e'(bus.opcode);
    assign w_cin_flag = bus.old_ALU_flag_NZCV[FLAG_C];

    // Incoming N and Z are never used: every op recomputes them.
    assign w_unused_flags = &{bus.old_ALU_flag_NZCV};

    // Operand routing for the shared adder.
    always_comb begin
        w_add_a   = bus.op1;
        w_add_b   = bus.op2;
        w_add_cin = 1'b0;
        case (w_op)
            ADC: begin
                w_add_cin = w_cin_flag;
            end
            SUB, CMP: begin
                w_add_b   = ~bus.op2;
                w_add_cin = 1'b1;
            end
            SBC: begin
                w_add_b   = ~bus.op2;
                w_add_cin = w_cin_flag;
            end
            RSB: begin
                w_add_a   = bus.op2;
                w_add_b   = ~bus.op1;
                w_add_cin = 1'b1;
            end
            RSC: begin
                w_add_a   = bus.op2;
                w_add_b   = ~bus.op1;
                w_add_cin = w_cin_flag;
            end
            default: begin
                w_add_a   = bus.op1;
                w_add_b   = bus.op2;
                w_add_cin = 1'b0;
            end
        endcase
    end

    alu_addsub #(.N(N)) u_addsub (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_ovf  (w_ovf)
    );

    always_comb begin
        w_logic_res = '0;
        case (w_op)
            AND:      w_logic_res = bus.op1 & bus.op2;
            EOR, TEQ: w_logic_res = bus.op1 ^ bus.op2;
            ORR:      w_logic_res = bus.op1 | bus.op2;
            NOR:      w_logic_res = ~(bus.op1 | bus.op2);
            BIC:      w_logic_res = bus.op1 & ~bus.op2;
            MOV:      w_logic_res = bus.op2;
            MVN:      w_logic_res = ~bus.op2;
            default:  w_logic_res = '0;
        endcase
    end

`ifdef ALU_LOGIC_CARRY_CLR_EN
    assign w_logic_cv = 2'b00;
`else
    assign w_logic_cv = {bus.old_ALU_flag_NZCV[FLAG_C], bus.old_ALU_flag_NZCV[FLAG_V]};
`endif

    always_comb begin
        w_res   = is_arith(w_op) ? w_sum : w_logic_res;
        w_flags = 4'b0000;
        w_flags[FLAG_N] = w_res[N-1];
        w_flags[FLAG_Z] = (w_res == '0);
        if (is_arith(w_op)) begin
            w_flags[FLAG_C] = w_cout;
            w_flags[FLAG_V] = w_ovf;
        end else begin
            w_flags[FLAG_C] = w_logic_cv[1];
            w_flags[FLAG_V] = w_logic_cv[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_flags <= 4'b0000;
        end else begin
            r_out   <= w_res;
            r_flags <= w_flags;
        end
    end

    assign bus.out           = r_out;
    assign bus.ALU_flag_NZCV = r_flags;

endmodule

// File: tb/tb_alu_processor.sv
// Directed-vector bench for alu_processor: hand-computed results and flags,
// back-to-back issue, and asynchronous reset behaviour.
module tb_alu_processor;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_processor_if #(.N(32)) bus ();

    alu_processor #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected C/V for logic and move ops given the incoming flags.
    function automatic logic [1:0] lcv(input logic [3:0] old_f);
`ifdef ALU_LOGIC_CARRY_CLR_EN
        lcv = 2'b00 & old_f[1:0];
`else
        lcv = old_f[1:0];
`endif
    endfunction

    task automatic drive(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f);
        @(negedge clk);
        bus.opcode            = op;
        bus.op1               = a;
        bus.op2               = b;
        bus.old_ALU_flag_NZCV = f;
    endtask

    // Issue one op, then sample its result just after the capturing edge.
    task automatic run_vec(input string tag, input alu_op_e op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] f,
                           input logic [31:0] exp_out, input logic [3:0] exp_f);
        drive(op, a, b, f);
        @(posedge clk);
        #1;
        check_val({tag, "_out"}, bus.out, exp_out);
        check_val({tag, "_nzcv"}, {28'd0, bus.ALU_flag_NZCV}, {28'd0, exp_f});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.opcode            = MOV;
        bus.op1               = 32'h0;
        bus.op2               = 32'hDEADBEEF;
        bus.old_ALU_flag_NZCV = 4'b1111;

        // Held in reset across edges with nonzero inputs: outputs stay clear.
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out", bus.out, 32'h0);
        check_val("rst_nzcv", {28'd0, bus.ALU_flag_NZCV}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("and",  AND, 32'hC9C9C9C9, 32'hA3A3A3A3, 4'b0000, 32'h81818181, 4'b1000);
        run_vec("bic",  BIC, 32'hC9C9C9C9, 32'hA3A3A3A3, 4'b0000, 32'h48484848, 4'b0000);
        run_vec("add",  ADD, 32'd1234, 32'd1234, 4'b0000, 32'd2468, 4'b0000);
        run_vec("addv", ADD, 32'h7FFFFFFF, 32'h1, 4'b0000, 32'h80000000, 4'b1001);
        run_vec("sub0", SUB, 32'd1234, 32'd1234, 4'b0000, 32'h0, 4'b0110);
        run_vec("sbc",  SBC, 32'd1234, 32'd1233, 4'b0000, 32'h0, 4'b0110);
        run_vec("rsc",  RSC, 32'd1234, 32'd5678, 4'b0000, 32'd4443, 4'b0010);
        run_vec("cmp",  CMP, 32'd9999, 32'd1111, 4'b0000, 32'd8888, 4'b0010);
        run_vec("mvn",  MVN, 32'h0, 32'd9999, 4'b0011, 32'hFFFFD8F0, {2'b10, lcv(4'b0011)});
        run_vec("eor",  EOR, 32'hF0F0F0F0, 32'hFFFFFFFF, 4'b0010, 32'h0F0F0F0F, {2'b00, lcv(4'b0010)});
        run_vec("orr",  ORR, 32'h0, 32'h0, 4'b1111, 32'h0, {2'b01, lcv(4'b1111)});
        run_vec("nor",  NOR, 32'h0, 32'h0, 4'b0001, 32'hFFFFFFFF, {2'b10, lcv(4'b0001)});
        run_vec("adc",  ADC, 32'hFFFFFFFF, 32'h0, 4'b0010, 32'h0, 4'b0110);
        run_vec("rsb",  RSB, 32'h1, 32'h0, 4'b0000, 32'hFFFFFFFF, 4'b1000);
        run_vec("teq",  TEQ, 32'h5, 32'h5, 4'b1110, 32'h0, {2'b01, lcv(4'b1110)});
        run_vec("cmn",  CMN, 32'h80000000, 32'h80000000, 4'b0000, 32'h0, 4'b0111);
        run_vec("mov",  MOV, 32'hFFFFFFFF, 32'h12345678, 4'b0100, 32'h12345678, {2'b00, lcv(4'b0100)});
        run_vec("subb", SUB, 32'h0, 32'h1, 4'b0000, 32'hFFFFFFFF, 4'b1000);
        run_vec("subv", SUB, 32'h80000000, 32'h1, 4'b0000, 32'h7FFFFFFF, 4'b0011);
        run_vec("sbc1", SBC, 32'd5, 32'd3, 4'b0010, 32'd2, 4'b0010);

        // Asynchronous reset between edges after a nonzero result.
        run_vec("pre", ADD, 32'd100, 32'd23, 4'b0000, 32'd123, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_out", bus.out, 32'h0);
        check_val("arst_nzcv", {28'd0, bus.ALU_flag_NZCV}, 32'h0);

        // An op presented during reset is discarded.
        drive(MVN, 32'h0, 32'h0, 4'b0011);
        @(posedge clk);
        #1;
        check_val("inrst_out", bus.out, 32'h0);
        check_val("inrst_nzcv", {28'd0, bus.ALU_flag_NZCV}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release captures the op then on the bus.
        run_vec("post", SUB, 32'd10, 32'd3, 4'b0000, 32'd7, 4'b0010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
